// File: rtl/cpu6502_timer_irq_peripheral_pkg.sv
// Shared register map, bit positions and control-register layout for the
// cpu6502 timer/IRQ/NMI peripheral.
package cpu6502_timer_irq_peripheral_pkg;

  localparam logic [2:0] REG_RELOAD_LO   = 3'd0;
  localparam logic [2:0] REG_RELOAD_HI   = 3'd1;
  localparam logic [2:0] REG_COUNT_LO    = 3'd2;
  localparam logic [2:0] REG_COUNT_HI    = 3'd3;
  localparam logic [2:0] REG_CONTROL     = 3'd4;
  localparam logic [2:0] REG_STATUS      = 3'd5;
  localparam logic [2:0] REG_NMI_TRIGGER = 3'd6;
  localparam logic [2:0] REG_SCRATCH     = 3'd7;

  localparam int CTRL_RUN_BIT          = 0;
  localparam int CTRL_AUTO_RELOAD_BIT  = 1;
  localparam int CTRL_IRQ_ENABLE_BIT   = 2;
  localparam int STATUS_EXPIRED_BIT    = 0;
  localparam int STATUS_NMI_ACTIVE_BIT = 1;

  // Member order makes the packed value match the CONTROL register bits.
  typedef struct packed {
    logic irq_enable;
    logic auto_reload;
    logic run;
  } t_timer_control;

endpackage

// File: rtl/cpu6502_timer_irq_peripheral_nmi_pulse.sv
// Retriggerable pulse generator: nmi_n is held low for PULSE_CYCLES clocks
// after the most recent trigger.
module cpu6502_nmi_pulse #(
  parameter int unsigned PULSE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic trigger,
  output logic nmi_n,
  output logic active
);

  logic [7:0] nmi_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nmi_cnt <= 8'd0;
      nmi_n   <= 1'b1;
    end else begin
      if (trigger)
        nmi_cnt <= 8'(PULSE_CYCLES);
      else if (nmi_cnt != 8'd0)
        nmi_cnt <= nmi_cnt - 8'd1;
      nmi_n <= (nmi_cnt == 8'd0);
    end
  end

  assign active = (nmi_cnt != 8'd0);

endmodule

// File: rtl/cpu6502_timer_irq_peripheral.sv
// Bus-mapped 16-bit down-counting timer driving irq_n, plus a software NMI
// pulse generator, decoded in an 8-byte window beside the SRAM.
module cpu6502_timer_irq_peripheral
  import cpu6502_timer_irq_peripheral_pkg::*;
#(
  parameter logic [15:0] BASE_ADDRESS     = 16'hFE00,
  parameter int unsigned NMI_PULSE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        bus_strobe,
  input  logic [15:0] address,
  input  logic        read_not_write,
  input  logic [7:0]  write_data,
  output logic [7:0]  read_data,
  output logic        selected,
  output logic        irq_n,
  output logic        nmi_n
);

  logic           hit, rd_hit, wr_hit;
  logic [2:0]     offset;
  logic [7:0]     reload_lo, reload_hi, snap_hi, scratch;
  logic [15:0]    count;
  t_timer_control ctrl;
  logic           expired, expire_evt, nmi_active;
  logic [7:0]     rd_value;

  assign hit        = bus_strobe && (address[15:3] == BASE_ADDRESS[15:3]);
  assign offset     = address[2:0];
  assign rd_hit     = hit && read_not_write;
  assign wr_hit     = hit && !read_not_write;
  assign expire_evt = ctrl.run && (count == 16'd0);

  // Timer and register file; bus writes take priority over timer updates,
  // but an expiry always sets the flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reload_lo <= 8'd0;
      reload_hi <= 8'd0;
      scratch   <= 8'd0;
      count     <= 16'd0;
      ctrl      <= '0;
      expired   <= 1'b0;
      irq_n     <= 1'b1;
    end else begin
      if (wr_hit && offset == REG_RELOAD_LO) reload_lo <= write_data;
      if (wr_hit && offset == REG_RELOAD_HI) reload_hi <= write_data;
      if (wr_hit && offset == REG_SCRATCH)   scratch   <= write_data;

      if (wr_hit && offset == REG_RELOAD_HI)
        count <= {write_data, reload_lo};
      else if (ctrl.run) begin
        if (count != 16'd0)
          count <= count - 16'd1;
        else if (ctrl.auto_reload)
          count <= {reload_hi, reload_lo};
      end

      if (wr_hit && offset == REG_CONTROL) begin
        ctrl.run         <= write_data[CTRL_RUN_BIT];
        ctrl.auto_reload <= write_data[CTRL_AUTO_RELOAD_BIT];
        ctrl.irq_enable  <= write_data[CTRL_IRQ_ENABLE_BIT];
      end else if (expire_evt && !ctrl.auto_reload)
        ctrl.run <= 1'b0;

      if (expire_evt)
        expired <= 1'b1;
      else if (wr_hit && offset == REG_STATUS && write_data[STATUS_EXPIRED_BIT])
        expired <= 1'b0;

      irq_n <= !(expired && ctrl.irq_enable);
    end
  end

  always_comb begin
    rd_value = 8'd0;
    case (offset)
      REG_RELOAD_LO: rd_value = reload_lo;
      REG_RELOAD_HI: rd_value = reload_hi;
      REG_COUNT_LO:  rd_value = count[7:0];
      REG_COUNT_HI:  rd_value = snap_hi;
      REG_CONTROL:   rd_value = {5'd0, ctrl};
      REG_STATUS: begin
        rd_value[STATUS_EXPIRED_BIT]    = expired;
        rd_value[STATUS_NMI_ACTIVE_BIT] = nmi_active;
      end
      REG_SCRATCH:   rd_value = scratch;
      default:       rd_value = 8'd0;
    endcase
  end

  // Read port: one-strobe latency, held between strobes like the SRAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_data <= 8'd0;
      selected  <= 1'b0;
      snap_hi   <= 8'd0;
    end else if (bus_strobe) begin
      selected <= rd_hit;
      if (rd_hit) read_data <= rd_value;
      if (rd_hit && offset == REG_COUNT_LO) snap_hi <= count[15:8];
    end
  end

  cpu6502_nmi_pulse #(
    .PULSE_CYCLES(NMI_PULSE_CYCLES)
  ) u_nmi_pulse (
    .clk    (clk),
    .reset_n(reset_n),
    .trigger(wr_hit && offset == REG_NMI_TRIGGER),
    .nmi_n  (nmi_n),
    .active (nmi_active)
  );

endmodule

// File: tb/tb_cpu6502_timer_irq_peripheral.sv
// Directed bench: bus reads push expected responses into a scoreboard that a
// separate monitor drains; interrupt timing is checked inline.
module tb_cpu6502_timer_irq_peripheral;
  import cpu6502_timer_irq_peripheral_pkg::*;

  localparam logic [15:0] BASE = 16'hFE00;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        bus_strobe = 1'b0;
  logic [15:0] address = 16'd0;
  logic        read_not_write = 1'b1;
  logic [7:0]  write_data = 8'd0;
  logic [7:0]  read_data;
  logic        selected, irq_n, nmi_n;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      name;
    logic       sel;
    logic [7:0] data;
  } exp_t;
  exp_t sb_q[$];

  cpu6502_timer_irq_peripheral #(
    .BASE_ADDRESS(BASE),
    .NMI_PULSE_CYCLES(16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus_strobe    (bus_strobe),
    .address       (address),
    .read_not_write(read_not_write),
    .write_data    (write_data),
    .read_data     (read_data),
    .selected      (selected),
    .irq_n         (irq_n),
    .nmi_n         (nmi_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: one response per read strobe, compared just after the edge.
  always @(posedge clk) begin
    exp_t e;
    if (reset_n && bus_strobe && read_not_write) begin
      #1;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard: read response with no expectation queued");
      end else begin
        e = sb_q.pop_front();
        check({e.name, " selected"}, 16'(selected), 16'(e.sel));
        if (e.sel) check({e.name, " data"}, 16'(read_data), 16'(e.data));
      end
    end
  end

  // Bus tasks are called at a negedge; the access lands on the next posedge.
  task automatic bus_write(input logic [2:0] off, input logic [7:0] d);
    address = BASE + 16'(off);
    read_not_write = 1'b0;
    write_data = d;
    bus_strobe = 1'b1;
    @(negedge clk);
    bus_strobe = 1'b0;
    read_not_write = 1'b1;
  endtask

  task automatic bus_read(input logic [15:0] a, input string name,
                          input logic sel, input logic [7:0] d);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.data = d;
    sb_q.push_back(e);
    address = a;
    read_not_write = 1'b1;
    bus_strobe = 1'b1;
    @(negedge clk);
    bus_strobe = 1'b0;
  endtask

  task automatic rd(input logic [2:0] off, input string name, input logic [7:0] d);
    bus_read(BASE + 16'(off), name, 1'b1, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    int pre;
    // 1: reset state and empty register file
    repeat (3) @(negedge clk);
    check("reset read_data", 16'(read_data), 16'h00);
    check("reset selected", 16'(selected), 16'h0);
    check("reset irq_n", 16'(irq_n), 16'h1);
    check("reset nmi_n", 16'(nmi_n), 16'h1);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) rd(3'(i), $sformatf("reset reg%0d", i), 8'h00);
    bus_read(16'h1234, "miss 0x1234", 1'b0, 8'h00);
    bus_read(16'hFE08, "miss 0xFE08", 1'b0, 8'h00);
    bus_write(REG_SCRATCH, 8'hA5);
    rd(REG_SCRATCH, "scratch", 8'hA5);
    bus_write(REG_CONTROL, 8'hF8);
    rd(REG_CONTROL, "control unused bits", 8'h00);
    bus_write(REG_COUNT_LO, 8'hFF);
    rd(REG_COUNT_LO, "count_lo read-only", 8'h00);
    check("idle irq_n", 16'(irq_n), 16'h1);
    check("idle nmi_n", 16'(nmi_n), 16'h1);

    // 2: auto-reload timer, reload 5 -> period 6
    bus_write(REG_RELOAD_LO, 8'h05);
    bus_write(REG_RELOAD_HI, 8'h00);
    bus_write(REG_CONTROL, 8'h07);
    repeat (6) @(negedge clk);
    check("irq_n at expiry edge", 16'(irq_n), 16'h1);
    @(negedge clk);
    check("irq_n after expiry", 16'(irq_n), 16'h0);
    bus_write(REG_STATUS, 8'h01);
    @(negedge clk);
    check("irq_n after clear", 16'(irq_n), 16'h1);
    repeat (3) @(negedge clk);
    check("irq_n before re-expiry", 16'(irq_n), 16'h1);
    @(negedge clk);
    check("irq_n re-expiry", 16'(irq_n), 16'h0);
    bus_write(REG_CONTROL, 8'h00);
    bus_write(REG_STATUS, 8'h01);
    @(negedge clk);
    check("irq_n stopped", 16'(irq_n), 16'h1);

    // 3: one-shot
    bus_write(REG_RELOAD_LO, 8'h03);
    bus_write(REG_RELOAD_HI, 8'h00);
    bus_write(REG_CONTROL, 8'h05);
    repeat (10) @(negedge clk);
    check("one-shot irq_n", 16'(irq_n), 16'h0);
    rd(REG_CONTROL, "one-shot control", 8'h04);
    rd(REG_COUNT_LO, "one-shot count_lo", 8'h00);
    rd(REG_COUNT_HI, "one-shot count_hi", 8'h00);
    rd(REG_STATUS, "one-shot status", 8'h01);
    bus_write(REG_STATUS, 8'h01);
    repeat (8) @(negedge clk);
    rd(REG_STATUS, "one-shot no re-expiry", 8'h00);
    check("one-shot irq_n cleared", 16'(irq_n), 16'h1);
    bus_write(REG_CONTROL, 8'h00);

    // 4: COUNT_HI snapshot
    bus_write(REG_RELOAD_LO, 8'h34);
    bus_write(REG_RELOAD_HI, 8'h12);
    rd(REG_COUNT_LO, "snap count_lo", 8'h34);
    bus_write(REG_RELOAD_HI, 8'h56);
    rd(REG_COUNT_HI, "snap count_hi", 8'h12);
    rd(REG_RELOAD_LO, "reload_lo", 8'h34);
    rd(REG_RELOAD_HI, "reload_hi", 8'h56);
    rd(REG_COUNT_LO, "resnap count_lo", 8'h34);
    rd(REG_COUNT_HI, "resnap count_hi", 8'h56);

    // 5: NMI pulse, single and retriggered
    bus_write(REG_NMI_TRIGGER, 8'h00);
    check("nmi_n before pulse", 16'(nmi_n), 16'h1);
    rd(REG_STATUS, "status nmi_active", 8'h02);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      if (!nmi_n) lows++;
      else if (lows > 0) break;
      @(negedge clk);
    end
    check("nmi pulse width", 16'(lows), 16'd16);
    rd(REG_STATUS, "status nmi idle", 8'h00);
    rd(REG_NMI_TRIGGER, "nmi_trigger reads 0", 8'h00);
    bus_write(REG_NMI_TRIGGER, 8'h00);
    pre = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (!nmi_n) pre++;
    end
    bus_write(REG_NMI_TRIGGER, 8'h00);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      if (!nmi_n) lows++;
      else break;
      @(negedge clk);
    end
    check("nmi retrigger width", 16'(pre + lows), 16'd26);

    // 6: expiry coincident with status clear; reset mid-pulse
    bus_write(REG_RELOAD_LO, 8'h02);
    bus_write(REG_RELOAD_HI, 8'h00);
    bus_write(REG_CONTROL, 8'h01);
    repeat (2) @(negedge clk);
    bus_write(REG_STATUS, 8'h01);
    rd(REG_STATUS, "set wins over clear", 8'h01);
    bus_write(REG_STATUS, 8'h01);
    bus_write(REG_RELOAD_LO, 8'h02);
    bus_write(REG_RELOAD_HI, 8'h00);
    bus_write(REG_CONTROL, 8'h07);
    repeat (5) @(negedge clk);
    check("irq_n before reset", 16'(irq_n), 16'h0);
    bus_write(REG_NMI_TRIGGER, 8'h00);
    repeat (3) @(negedge clk);
    check("nmi_n before reset", 16'(nmi_n), 16'h0);
    reset_n = 1'b0;
    #1;
    check("nmi_n async reset", 16'(nmi_n), 16'h1);
    check("irq_n async reset", 16'(irq_n), 16'h1);
    @(negedge clk);
    reset_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!nmi_n || !irq_n) lows++;
    end
    check("no residual interrupts", 16'(lows), 16'd0);
    rd(REG_CONTROL, "control after reset", 8'h00);
    rd(REG_STATUS, "status after reset", 8'h00);

    @(negedge clk);
    check("scoreboard drained", 16'(sb_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
